// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Serial UART transmitter. A word offered on tx_data/tx_valid is accepted
//   when the block is idle, then sent as one frame: a start bit (low), the data
//   bits LSB first, an optional odd/even parity bit, and one or two stop bits
//   (high). Each frame bit is held for CLKS_PER_BIT clocks.
//
//   Parameters
//     CLKS_PER_BIT  clocks per serial bit (2..65535)
//     DATA_BITS     data bits per frame (5..9)
//     PARITY        0 = none, 1 = odd, 2 = even
//     STOP_BITS     stop bits per frame (1 or 2)
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high reset
//     tx_data     word to transmit
//     tx_valid    tx_data holds a valid word
//     tx_ready    block can accept a word this cycle (equals ~busy)
//     tx          registered serial line, idle high
//     busy        a frame is in progress
//     frame_done  one-cycle pulse in the cycle after the last stop-bit clock
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parBit;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_frameDone;

  logic w_accept;
  logic w_baudEnd;
  logic w_lastData;
  logic w_lastStop;
  logic w_parIn;

  assign w_accept   = tx_valid & ~r_busy;
  assign w_baudEnd  = (r_baud == CW'(CLKS_PER_BIT - 1));
  assign w_lastData = (r_bitCnt == BW'(DATA_BITS - 1));
  assign w_lastStop = (r_bitCnt == BW'(STOP_BITS - 1));

  // Parity is captured together with the word at acceptance, so later changes
  // on tx_data cannot affect the bit that goes out on the line.
  assign w_parIn = (PARITY == 1) ? ~^tx_data : ^tx_data;

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_ready   = ~r_busy;
  assign frame_done = r_frameDone;

  // Frame sequencer. The bit counter is reused to count stop bits, since the
  // data phase is over by then. The next line value is registered on the same
  // edge that changes state, so tx changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parBit    <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_baudEnd ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_state  <= S_START;
            r_shift  <= tx_data;
            r_parBit <= w_parIn;
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_busy   <= 1'b1;
            r_tx     <= 1'b0;
          end
        end
        S_START: begin
          if (w_baudEnd) begin
            r_state  <= S_DATA;
            r_bitCnt <= '0;
            r_tx     <= r_shift[0];
            r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
          end
        end
        S_DATA: begin
          if (w_baudEnd) begin
            if (w_lastData) begin
              r_bitCnt <= '0;
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_tx    <= r_parBit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end
        end
        S_PAR: begin
          if (w_baudEnd) begin
            r_state  <= S_STOP;
            r_bitCnt <= '0;
            r_tx     <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_baudEnd) begin
            if (w_lastStop) begin
              r_state     <= S_IDLE;
              r_bitCnt    <= '0;
              r_busy      <= 1'b0;
              r_frameDone <= 1'b1;
              r_tx        <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
